// File: rtl/fpu_add_scheduler_pkg.sv
// Shared types for the FP-add scheduler: FSM state encoding, default width
// and a small one-hot decode helper.
package fpu_add_scheduler_pkg;

    localparam int FP_W = 32;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_RESP  = 3'd3,
        S_CLEAR = 3'd4
    } state_e;

    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        return 8'd1 << idx;
    endfunction

endpackage

// File: rtl/fpu_add_scheduler_if.sv
// Requester-side bus of the FP-add scheduler: requests/operands in,
// grants and one-hot responses out.
interface fpu_add_scheduler_if #(
    parameter int NREQ = 2,
    parameter int W    = 32
);
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] op_a;
    logic [NREQ*W-1:0] op_b;
    logic [NREQ-1:0]   op_sub;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   rsp_valid;
    logic [W-1:0]      rsp_result;
    logic              rsp_err;
    logic              busy;

    modport master (
        output req, op_a, op_b, op_sub,
        input  gnt, rsp_valid, rsp_result, rsp_err, busy
    );

    modport slave (
        input  req, op_a, op_b, op_sub,
        output gnt, rsp_valid, rsp_result, rsp_err, busy
    );
endinterface

// File: rtl/fpu_add_scheduler_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping from NREQ-1 back to 0.
module rr_pick #(
    parameter int NREQ = 2,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [PW-1:0]   winner,
    output logic            any
);
    localparam int SW = PW + 1;

    logic [SW-1:0] idx_s;

    // Scan offsets from farthest to nearest so the nearest set request wins
    always_comb begin
        winner = {PW{1'b0}};
        any    = 1'b0;
        idx_s  = {SW{1'b0}};
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx_s = {1'b0, ptr} + SW'(i);
            if (idx_s >= SW'(NREQ)) begin
                idx_s = idx_s - SW'(NREQ);
            end else begin
                idx_s = idx_s;
            end
            if (req[idx_s[PW-1:0]]) begin
                winner = idx_s[PW-1:0];
                any    = 1'b1;
            end else begin
                winner = winner;
                any    = any;
            end
        end
    end
endmodule

// File: rtl/fpu_add_scheduler.sv
// Shares one FP add/normalise/round unit between NREQ requesters with
// round-robin arbitration, start/clear sequencing and a completion watchdog.
module fpu_add_scheduler
    import fpu_add_scheduler_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int W       = FP_W,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    fpu_add_scheduler_if.slave    bus,
    output logic                  fpu_start,
    output logic                  fpu_clear,
    output logic [W-1:0]          fpu_a,
    output logic [W-1:0]          fpu_b,
    output logic                  fpu_sub,
    input  logic                  fpu_done,
    input  logic [W-1:0]          fpu_result
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TIMEOUT) + 1;

    state_e            state_r, state_s;
    logic [PW-1:0]     ptr_r, owner_r, winner_s;
    logic              any_s;
    logic [TW-1:0]     timer_r;
    logic [W-1:0]      a_r, b_r, rsp_result_r;
    logic              sub_r, rsp_err_r;
    logic [NREQ-1:0]   gnt_r, rsp_valid_r;
    logic              busy_r, start_r, clear_r;

    rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req    (bus.req),
        .ptr    (ptr_r),
        .winner (winner_s),
        .any    (any_s)
    );

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (any_s) state_s = S_ISSUE;
                else       state_s = S_IDLE;
            end
            S_ISSUE: state_s = S_WAIT;
            S_WAIT: begin
                if (fpu_done || (timer_r == TW'(TIMEOUT - 1))) state_s = S_RESP;
                else                                          state_s = S_WAIT;
            end
            S_RESP:  state_s = S_CLEAR;
            S_CLEAR: state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // State, captured operands, result, watchdog and registered pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= S_IDLE;
            ptr_r        <= {PW{1'b0}};
            owner_r      <= {PW{1'b0}};
            timer_r      <= {TW{1'b0}};
            a_r          <= {W{1'b0}};
            b_r          <= {W{1'b0}};
            sub_r        <= 1'b0;
            rsp_result_r <= {W{1'b0}};
            rsp_err_r    <= 1'b0;
            gnt_r        <= {NREQ{1'b0}};
            rsp_valid_r  <= {NREQ{1'b0}};
            busy_r       <= 1'b0;
            start_r      <= 1'b0;
            clear_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            busy_r      <= (state_s != S_IDLE);
            gnt_r       <= {NREQ{1'b0}};
            rsp_valid_r <= {NREQ{1'b0}};
            start_r     <= 1'b0;
            clear_r     <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (any_s) begin
                        owner_r <= winner_s;
                        a_r     <= bus.op_a[winner_s * W +: W];
                        b_r     <= bus.op_b[winner_s * W +: W];
                        sub_r   <= bus.op_sub[winner_s];
                        gnt_r   <= NREQ'(onehot8(3'(winner_s)));
                        start_r <= 1'b1;
                    end
                end
                S_ISSUE: timer_r <= {TW{1'b0}};
                S_WAIT: begin
                    // A completion in the watchdog's last cycle still counts as success
                    if (fpu_done) begin
                        rsp_result_r <= fpu_result;
                        rsp_err_r    <= 1'b0;
                        rsp_valid_r  <= NREQ'(onehot8(3'(owner_r)));
                    end else if (timer_r == TW'(TIMEOUT - 1)) begin
                        rsp_result_r <= {W{1'b0}};
                        rsp_err_r    <= 1'b1;
                        rsp_valid_r  <= NREQ'(onehot8(3'(owner_r)));
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end
                S_RESP: clear_r <= 1'b1;
                S_CLEAR: begin
                    if (owner_r == PW'(NREQ - 1)) ptr_r <= {PW{1'b0}};
                    else                          ptr_r <= owner_r + PW'(1);
                end
                default: clear_r <= 1'b0;
            endcase
        end
    end

    assign bus.gnt        = gnt_r;
    assign bus.rsp_valid  = rsp_valid_r;
    assign bus.rsp_result = rsp_result_r;
    assign bus.rsp_err    = rsp_err_r;
    assign bus.busy       = busy_r;
    assign fpu_start      = start_r;
    // Reset also forces the shared unit back to its initial state
    assign fpu_clear      = reset | clear_r;
    assign fpu_a          = a_r;
    assign fpu_b          = b_r;
    assign fpu_sub        = sub_r;
endmodule

// File: tb/tb_fpu_add_scheduler.sv
// Directed bench for fpu_add_scheduler with a behavioural FP unit and
// grant/response scoreboards.
module tb_fpu_add_scheduler;
    localparam int NREQ    = 2;
    localparam int W       = 32;
    localparam int TIMEOUT = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          fpu_start, fpu_clear, fpu_sub, fpu_done;
    logic [W-1:0]  fpu_a, fpu_b, fpu_result;

    int errors = 0;
    int checks = 0;
    int unit_lat;
    int unit_cnt;
    logic unit_busy;

    typedef struct packed {logic [1:0] gnt; logic [31:0] a; logic [31:0] b; logic sub;} gnt_t;
    typedef struct packed {logic [1:0] vld; logic [31:0] res; logic err;} rsp_t;
    gnt_t gnt_q[$];
    rsp_t rsp_q[$];
    gnt_t g_m;
    rsp_t r_m;

    always #5 clk = ~clk;

    fpu_add_scheduler_if #(.NREQ(NREQ), .W(W)) bus ();

    fpu_add_scheduler #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .fpu_start  (fpu_start),
        .fpu_clear  (fpu_clear),
        .fpu_a      (fpu_a),
        .fpu_b      (fpu_b),
        .fpu_sub    (fpu_sub),
        .fpu_done   (fpu_done),
        .fpu_result (fpu_result)
    );

    function automatic logic [31:0] unit_fn(input logic [31:0] a, input logic [31:0] b, input logic sub);
        if (a == 32'h3F800000 && b == 32'h40000000 && !sub) return 32'h40400000;
        else return a ^ {b[15:0], b[31:16]} ^ {31'b0, sub};
    endfunction

    function void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endfunction

    // Behavioural FP unit: done after unit_lat cycles, never if unit_lat < 1
    always @(posedge clk) begin
        if (fpu_clear) begin
            fpu_done <= 1'b0; unit_busy <= 1'b0; unit_cnt <= 0; fpu_result <= 32'h0;
        end else if (fpu_start) begin
            unit_busy <= 1'b1; unit_cnt <= 1;
        end else if (unit_busy && !fpu_done && unit_lat > 0) begin
            if (unit_cnt == unit_lat) begin
                fpu_done   <= 1'b1;
                fpu_result <= unit_fn(fpu_a, fpu_b, fpu_sub);
            end else begin
                unit_cnt <= unit_cnt + 1;
            end
        end
    end

    // Scoreboard monitor for grant and response pulses
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.gnt != 2'b00) begin
                if (gnt_q.size() == 0) chk("unexpected_gnt", {30'b0, bus.gnt}, 32'h0);
                else begin
                    g_m = gnt_q.pop_front();
                    chk("gnt_vec", {30'b0, bus.gnt}, {30'b0, g_m.gnt});
                    chk("gnt_start", {31'b0, fpu_start}, 32'h1);
                    chk("gnt_fpu_a", fpu_a, g_m.a);
                    chk("gnt_fpu_b", fpu_b, g_m.b);
                    chk("gnt_fpu_sub", {31'b0, fpu_sub}, {31'b0, g_m.sub});
                end
            end
            if (bus.rsp_valid != 2'b00) begin
                if (rsp_q.size() == 0) chk("unexpected_rsp", {30'b0, bus.rsp_valid}, 32'h0);
                else begin
                    r_m = rsp_q.pop_front();
                    chk("rsp_vec", {30'b0, bus.rsp_valid}, {30'b0, r_m.vld});
                    chk("rsp_result", bus.rsp_result, r_m.res);
                    chk("rsp_err", {31'b0, bus.rsp_err}, {31'b0, r_m.err});
                end
            end
        end
    end

    task automatic wait_gnt(input int budget);
        int n = 0;
        do begin @(negedge clk); n++; end while (bus.gnt == 2'b00 && n < budget);
        if (bus.gnt == 2'b00) chk("gnt_wait_bound", {31'b0, |bus.gnt}, 32'h1);
    endtask

    task automatic wait_rsp(input int budget, output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (bus.rsp_valid == 2'b00 && n < budget);
        if (bus.rsp_valid == 2'b00) chk("rsp_wait_bound", {31'b0, |bus.rsp_valid}, 32'h1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        do begin @(negedge clk); n++; end while (bus.busy && n < budget);
        if (bus.busy) chk("idle_wait_bound", {31'b0, bus.busy}, 32'h0);
    endtask

    task automatic set_ops(input int r, input logic [31:0] a, input logic [31:0] b, input logic s);
        bus.op_a[r*32 +: 32] = a;
        bus.op_b[r*32 +: 32] = b;
        bus.op_sub[r] = s;
    endtask

    logic [31:0] ta [4] = '{32'hC1200000, 32'h41A00000, 32'h3E800000, 32'h42C80000};
    logic [31:0] tb [4] = '{32'h40A00000, 32'hBF000000, 32'h41100000, 32'h3F000000};
    logic        ts [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        int n;
        logic [1:0] oh;
        reset = 1'b1; bus.req = 2'b00; bus.op_a = '0; bus.op_b = '0; bus.op_sub = 2'b00;
        unit_lat = 5;
        @(negedge clk); @(negedge clk);
        chk("rst_gnt", {30'b0, bus.gnt}, 32'h0);
        chk("rst_rsp_valid", {30'b0, bus.rsp_valid}, 32'h0);
        chk("rst_busy", {31'b0, bus.busy}, 32'h0);
        chk("rst_start", {31'b0, fpu_start}, 32'h0);
        chk("rst_clear", {31'b0, fpu_clear}, 32'h1);
        chk("rst_fpu_a", fpu_a, 32'h0);
        chk("rst_result", bus.rsp_result, 32'h0);
        chk("rst_err", {31'b0, bus.rsp_err}, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_clear", {31'b0, fpu_clear}, 32'h0);

        // Test 1: single add, latency and pulse shapes
        set_ops(0, 32'h3F800000, 32'h40000000, 1'b0);
        bus.req = 2'b01;
        gnt_q.push_back('{2'b01, 32'h3F800000, 32'h40000000, 1'b0});
        rsp_q.push_back('{2'b01, 32'h40400000, 1'b0});
        @(negedge clk);
        chk("t1_gnt_latency", {30'b0, bus.gnt}, 32'h1);
        bus.req = 2'b00;
        @(negedge clk);
        chk("t1_start_pulse", {31'b0, fpu_start}, 32'h0);
        wait_rsp(200, n);
        chk("t1_rsp_latency", n, 32'd6);
        @(negedge clk);
        chk("t1_clear_after_rsp", {31'b0, fpu_clear}, 32'h1);
        chk("t1_rsp_valid_pulse", {30'b0, bus.rsp_valid}, 32'h0);
        @(negedge clk);
        chk("t1_idle", {31'b0, bus.busy}, 32'h0);
        chk("t1_rsp_hold", bus.rsp_result, 32'h40400000);

        // Test 2: both requesters held, alternating grants
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        unit_lat = 3;
        set_ops(0, ta[0], tb[0], ts[0]);
        set_ops(1, ta[1], tb[1], ts[1]);
        for (int k = 0; k < 4; k++) begin
            oh = (k % 2 == 0) ? 2'b01 : 2'b10;
            gnt_q.push_back('{oh, ta[k], tb[k], ts[k]});
            rsp_q.push_back('{oh, unit_fn(ta[k], tb[k], ts[k]), 1'b0});
        end
        bus.req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(100);
            if (k < 2) set_ops(k % 2, ta[k+2], tb[k+2], ts[k+2]);
            else bus.req[k % 2] = 1'b0;
        end
        wait_idle(100);
        chk("t2_all_gnt", gnt_q.size(), 32'd0);
        chk("t2_all_rsp", rsp_q.size(), 32'd0);

        // Test 3: unit never completes, watchdog abort
        unit_lat = -1;
        set_ops(1, 32'h40490FDB, 32'h3F000000, 1'b1);
        gnt_q.push_back('{2'b10, 32'h40490FDB, 32'h3F000000, 1'b1});
        rsp_q.push_back('{2'b10, 32'h0, 1'b1});
        bus.req = 2'b10;
        wait_gnt(50);
        bus.req = 2'b00;
        wait_rsp(200, n);
        chk("t3_timeout_latency", n, 32'd65);
        @(negedge clk);
        chk("t3_clear", {31'b0, fpu_clear}, 32'h1);
        @(negedge clk);
        chk("t3_idle", {31'b0, bus.busy}, 32'h0);

        // Test 4a: done one cycle too late, timeout wins
        unit_lat = 64;
        gnt_q.push_back('{2'b10, 32'h40490FDB, 32'h3F000000, 1'b1});
        rsp_q.push_back('{2'b10, 32'h0, 1'b1});
        bus.req = 2'b10;
        wait_gnt(50);
        bus.req = 2'b00;
        wait_rsp(200, n);
        chk("t4a_latency", n, 32'd65);
        wait_idle(20);

        // Test 4b: done in the watchdog's last cycle, done wins
        unit_lat = 63;
        set_ops(0, 32'h41200000, 32'hC0400000, 1'b0);
        gnt_q.push_back('{2'b01, 32'h41200000, 32'hC0400000, 1'b0});
        rsp_q.push_back('{2'b01, unit_fn(32'h41200000, 32'hC0400000, 1'b0), 1'b0});
        bus.req = 2'b01;
        wait_gnt(50);
        bus.req = 2'b00;
        wait_rsp(200, n);
        chk("t4b_latency", n, 32'd65);
        wait_idle(20);

        // Test 5: reset while waiting drops the transaction and the pointer
        unit_lat = -1;
        gnt_q.push_back('{2'b10, 32'h40490FDB, 32'h3F000000, 1'b1});
        bus.req = 2'b10;
        wait_gnt(50);
        bus.req = 2'b00;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("t5_clear_in_reset", {31'b0, fpu_clear}, 32'h1);
        @(negedge clk);
        reset = 1'b0;
        chk("t5_idle_after_reset", {31'b0, bus.busy}, 32'h0);
        repeat (80) @(negedge clk);
        chk("t5_no_rsp", rsp_q.size(), 32'd0);
        unit_lat = 3;
        gnt_q.push_back('{2'b01, 32'h41200000, 32'hC0400000, 1'b0});
        rsp_q.push_back('{2'b01, unit_fn(32'h41200000, 32'hC0400000, 1'b0), 1'b0});
        bus.req = 2'b11;
        wait_gnt(50);
        chk("t5_ptr_reset", {30'b0, bus.gnt}, 32'h1);
        bus.req = 2'b00;
        wait_idle(50);

        // Test 6: one-cycle req pulse while busy is never granted
        unit_lat = 10;
        gnt_q.push_back('{2'b01, 32'h41200000, 32'hC0400000, 1'b0});
        rsp_q.push_back('{2'b01, unit_fn(32'h41200000, 32'hC0400000, 1'b0), 1'b0});
        bus.req = 2'b01;
        wait_gnt(50);
        bus.req = 2'b00;
        @(negedge clk);
        set_ops(1, 32'h3DCCCCCD, 32'h3E4CCCCD, 1'b1);
        bus.req = 2'b10;
        @(negedge clk);
        bus.req = 2'b00;
        wait_idle(50);
        repeat (5) @(negedge clk);
        chk("t6_no_stale_gnt", gnt_q.size(), 32'd0);
        gnt_q.push_back('{2'b10, 32'h3DCCCCCD, 32'h3E4CCCCD, 1'b1});
        rsp_q.push_back('{2'b10, unit_fn(32'h3DCCCCCD, 32'h3E4CCCCD, 1'b1), 1'b0});
        bus.req = 2'b10;
        wait_gnt(50);
        chk("t6_late_gnt", {30'b0, bus.gnt}, 32'h2);
        bus.req = 2'b00;
        wait_idle(50);
        chk("end_gnt_q", gnt_q.size(), 32'd0);
        chk("end_rsp_q", rsp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
